// File: rtl/prefix_arb_pkg.sv
// prefix_arb_pkg: shared types and sizes for the prefix adder arbiter
package prefix_arb_pkg;
  localparam int ARB_N = 32;
  localparam int ARB_NREQ = 4;
  localparam int ARB_IDW = $clog2(ARB_NREQ);
  localparam int OPCNT_W = 16;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  typedef struct packed {
    logic [ARB_N-1:0] a;
    logic [ARB_N-1:0] b;
    logic cin;
    logic [ARB_IDW-1:0] id;
  } opr_t;
endpackage

// File: rtl/prefix.sv
// prefix: Kogge-Stone parallel prefix adder with carry-in and carry-out
module prefix #(
  parameter int N = 32
) (
  input logic [N-1:0] a,
  input logic [N-1:0] b,
  input logic cin,
  output logic [N-1:0] sum,
  output logic cout
);
  localparam int L = $clog2(N);
  logic [N-1:0] g [0:L];
  logic [N-1:0] p [0:L];
  logic [N:0] c;
  assign g[0] = a & b;
  assign p[0] = a ^ b;
  for (genvar k = 0; k < L; k++) begin : g_lvl
    assign g[k+1] = g[k] | (p[k] & (g[k] << (1 << k)));
    assign p[k+1] = p[k] & ((p[k] << (1 << k)) | ({N{1'b1}} >> (N - (1 << k))));
  end
  assign c = {g[L] | (p[L] & {N{cin}}), cin};
  assign sum = p[0] ^ c[N-1:0];
  assign cout = c[N];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first active request at or after ptr
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input logic [NREQ-1:0] req,
  input logic [IDW-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0] idx
);
  logic [IDW-1:0] j;
  // scan from the farthest offset down so the nearest active request wins
  always_comb begin
    gnt = '0;
    idx = '0;
    j = '0;
    for (int o = NREQ - 1; o >= 0; o--) begin
      j = IDW'((int'(ptr) + o) % NREQ);
      if (req[j]) begin
        idx = j;
        gnt = NREQ'(1) << j;
      end
    end
  end
endmodule

// File: rtl/prefix_adder_arb.sv
// prefix_adder_arb: round-robin sharing of one prefix adder; PREFIX_ARB_SUB_EN adds req_sub subtract
module prefix_adder_arb
  import prefix_arb_pkg::*;
#(
  parameter int N = ARB_N,
  parameter int NREQ = ARB_NREQ,
  parameter int IDW = $clog2(NREQ)
) (
  input logic clk,
  input logic reset,
  input logic [NREQ-1:0] req_valid,
  output logic [NREQ-1:0] req_ready,
  input logic [NREQ-1:0][N-1:0] req_a,
  input logic [NREQ-1:0][N-1:0] req_b,
  input logic [NREQ-1:0] req_cin,
`ifdef PREFIX_ARB_SUB_EN
  input logic [NREQ-1:0] req_sub,
`endif
  output logic rsp_valid,
  input logic rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [N-1:0] rsp_sum,
  output logic rsp_cout,
  output logic [OPCNT_W-1:0] op_count
);
  state_t st, nst;
  opr_t opr;
  logic [IDW-1:0] ptr, gidx;
  logic [NREQ-1:0] gnt;
  logic any, acc, done, sub;
  logic [N-1:0] sum;
  logic cout;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (.req(req_valid), .ptr(ptr), .gnt(gnt), .idx(gidx));
  prefix #(.N(N)) u_add (.a(opr.a), .b(opr.b), .cin(opr.cin), .sum(sum), .cout(cout));
`ifdef PREFIX_ARB_SUB_EN
  assign sub = req_sub[gidx];
`else
  assign sub = 1'b0;
`endif
  assign rsp_valid = st == HOLD;
  // accept in IDLE or when HOLD's response drains, so HOLD->EXEC skips the IDLE bubble
  always_comb begin
    any = |req_valid;
    done = st == HOLD && rsp_ready;
    acc = !reset && any && (st == IDLE || done);
    req_ready = acc ? gnt : '0;
    nst = acc ? EXEC : st == EXEC ? HOLD : (st == HOLD && !rsp_ready) ? HOLD : IDLE;
  end
  // state register
  always_ff @(posedge clk) st <= reset ? IDLE : nst;
  // operand capture, result register, rr pointer and completion counter
  always_ff @(posedge clk) begin
    if (reset) begin
      opr <= '0;
      ptr <= '0;
      rsp_id <= '0;
      rsp_sum <= '0;
      rsp_cout <= 1'b0;
      op_count <= '0;
    end else begin
      if (acc) begin
        opr <= '{a: req_a[gidx], b: sub ? ~req_b[gidx] : req_b[gidx], cin: sub | req_cin[gidx], id: gidx};
        ptr <= gidx == IDW'(NREQ - 1) ? '0 : gidx + 1'b1;
      end
      if (st == EXEC) begin
        rsp_id <= opr.id;
        rsp_sum <= sum;
        rsp_cout <= cout;
      end
      if (done) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_prefix_adder_arb.sv
// tb_prefix_adder_arb: scoreboard bench with a round-robin/arithmetic reference model
module tb_prefix_adder_arb;
  import prefix_arb_pkg::*;
  localparam int N = ARB_N;
  localparam int NREQ = ARB_NREQ;
  logic clk = 1'b0;
  logic reset;
  logic [NREQ-1:0] req_valid, req_ready, req_cin, sub_v, sticky;
  logic [NREQ-1:0][N-1:0] req_a, req_b;
  logic rsp_valid, rsp_ready, rsp_cout;
  logic [ARB_IDW-1:0] rsp_id;
  logic [N-1:0] rsp_sum;
  logic [OPCNT_W-1:0] op_count;
  typedef struct {
    int id;
    logic [N-1:0] sum;
    logic cout;
    int vis;
  } exp_t;
  exp_t q[$];
  int errs = 0, checks = 0, cyc = 0, pops = 0, vis = -1, mptr = 0;
  bit seen = 0, rnd = 0;

  prefix_adder_arb dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin),
`ifdef PREFIX_ARB_SUB_EN
    .req_sub(sub_v),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .op_count(op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic exp_t model_rsp(input int g);
    exp_t e;
    logic [N:0] t;
    e.id = g;
    t = {1'b0, req_a[g]} + {1'b0, req_b[g]} + (N+1)'(req_cin[g]);
`ifdef PREFIX_ARB_SUB_EN
    if (sub_v[g]) t = {req_a[g] >= req_b[g], req_a[g] - req_b[g]};
`endif
    e.sum = t[N-1:0];
    e.cout = t[N];
    e.vis = 0;
    return e;
  endfunction

  task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic c, input logic s);
    req_a[i] = a;
    req_b[i] = b;
    req_cin[i] = c;
    sub_v[i] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic rand_req(input int i);
    logic [N-1:0] a;
    a = $urandom;
    set_req(i, a, ($urandom_range(0, 7) == 0) ? ~a : N'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic step();
    int g;
    bit free;
    exp_t e;
    logic [NREQ-1:0] er;
    g = -1;
    #1;
    if (reset) begin
      chk("ready_in_reset", 64'(req_ready), 64'd0);
      q.delete();
      vis = -1;
      mptr = 0;
      pops = 0;
      seen = 0;
    end else begin
      free = vis < 0 || (cyc >= vis && rsp_ready);
      for (int o = 0; o < NREQ && free && g < 0; o++)
        if (req_valid[(mptr + o) % NREQ]) g = (mptr + o) % NREQ;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(er));
      if (g >= 0) begin
        e = model_rsp(g);
        e.vis = cyc + 2;
        q.push_back(e);
        mptr = (g + 1) % NREQ;
        vis = cyc + 2;
      end else if (vis >= 0 && cyc >= vis && rsp_ready) vis = -1;
    end
    @(negedge clk);
    cyc++;
    if (g >= 0) begin
      req_valid[g] = rnd ? 1'($urandom_range(0, 1)) : sticky[g];
      if (rnd && req_valid[g]) rand_req(g);
    end
    if (rnd) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_req(i);
      rsp_ready = $urandom_range(0, 3) != 0;
    end
  endtask

  // monitor: compare every presented response with the head of the scoreboard
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      chk("op_count", 64'(op_count), 64'(pops));
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checks++;
          errs++;
          $display("FAIL unexpected_rsp: got rsp id %0d sum %0h with no request outstanding (cycle %0d)", rsp_id, rsp_sum, cyc);
        end else begin
          if (!seen) begin
            chk("latency", 64'(cyc), 64'(q[0].vis));
            seen = 1;
          end
          chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
          chk("rsp_sum", 64'(rsp_sum), 64'(q[0].sum));
          chk("rsp_cout", 64'(rsp_cout), 64'(q[0].cout));
          if (rsp_ready) begin
            void'(q.pop_front());
            pops++;
            seen = 0;
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_cin = '0;
    sub_v = '0;
    sticky = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    step();
    step();
    reset = 1'b0;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(rsp_id), 64'd0);
    chk("reset_rsp_sum", 64'(rsp_sum), 64'd0);
    chk("reset_rsp_cout", 64'(rsp_cout), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    set_req(0, 32'd5, 32'd7, 1'b0, 1'b0);
    repeat (6) step();
    set_req(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    repeat (5) step();
    sticky = '1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'(100 * i), 32'(i + 1), 1'b0, 1'b0);
    repeat (12) step();
    rsp_ready = 1'b0;
    repeat (5) step();
    rsp_ready = 1'b1;
    repeat (4) step();
    sticky = '0;
    repeat (12) step();
    set_req(0, 32'd9, 32'd9, 1'b1, 1'b0);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    set_req(0, 32'd1, 32'd2, 1'b0, 1'b0);
    set_req(1, 32'd3, 32'd4, 1'b1, 1'b0);
    repeat (8) step();
`ifdef PREFIX_ARB_SUB_EN
    set_req(1, 32'd10, 32'd3, 1'b0, 1'b1);
    repeat (5) step();
    set_req(1, 32'd3, 32'd10, 1'b1, 1'b1);
    repeat (5) step();
`endif
    rnd = 1;
    repeat (3000) step();
    rnd = 0;
    sticky = '0;
    rsp_ready = 1'b1;
    repeat (40) step();
    chk("drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
